// File: rtl/trigcap_pkg.sv
// Shared types and the level-crossing rule for the trigger_capture block.
package trigcap_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRETRIG,
        WAIT_TRIG,
        POSTTRIG,
        READOUT
    } state_e;

    // Unsigned crossing test; callers zero-extend their samples to 32 bits.
    function automatic logic crossed(input logic [31:0] prev, input logic [31:0] cur,
                                     input logic [31:0] level, input logic falling);
        return falling ? (prev > level && cur <= level) : (prev < level && cur >= level);
    endfunction

endpackage

// File: rtl/trigcap_ram.sv
// Capture buffer: one write port, one registered read port, contents not reset.
module trigcap_ram #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/trigger_capture.sv
// Armed oscilloscope capture: circular pre-trigger fill, level-crossing trigger, oldest-first readout.
// Optional forced trigger after AUTO_TIMEOUT waiting samples when TRIGCAP_AUTO_EN is defined.
module trigger_capture
    import trigcap_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 256,
    parameter int ADDR_W       = $clog2(DEPTH),
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  sample_in,
    input  logic              sample_valid,
    input  logic              arm,
    input  logic [WIDTH-1:0]  trig_level,
    input  logic              trig_falling,
    input  logic [ADDR_W-1:0] pre_count,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              rd_last,
    input  logic              rd_ready,
    output logic              busy,
    output logic              triggered,
    output logic              trig_forced
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, beat_q, beat_d, pre_q, pre_d;
    logic [WIDTH-1:0]  level_q, level_d, prev_q, prev_d;
    logic              fall_q, fall_d, prev_vld_q, prev_vld_d;
    logic              trig_q, trig_d, rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic              we, re, hit, force_trig;
    logic [WIDTH-1:0]  ram_q;

`ifdef TRIGCAP_AUTO_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
    logic [TO_W-1:0] to_q, to_d;
    logic            forced_q, forced_d;
    assign force_trig  = sample_valid && (to_q == TO_W'(AUTO_TIMEOUT - 1));
    assign trig_forced = forced_q;
`else
    logic unused_auto;
    assign unused_auto = (AUTO_TIMEOUT != 0);
    assign force_trig  = 1'b0;
    assign trig_forced = 1'b0;
`endif

    assign hit = sample_valid && prev_vld_q &&
                 crossed(32'(prev_q), 32'(sample_in), 32'(level_q), fall_q);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        pre_d      = pre_q;
        level_d    = level_q;
        fall_d     = fall_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        trig_d     = trig_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        we         = 1'b0;
        re         = 1'b0;
`ifdef TRIGCAP_AUTO_EN
        to_d       = to_q;
        forced_d   = forced_q;
`endif
        if (state_q inside {PRETRIG, WAIT_TRIG, POSTTRIG} && sample_valid) begin
            we         = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            prev_d     = sample_in;
            prev_vld_d = 1'b1;
        end
        case (state_q)
            IDLE: if (arm) begin
                level_d    = trig_level;
                fall_d     = trig_falling;
                pre_d      = pre_count;
                cnt_d      = '0;
                prev_vld_d = 1'b0;
`ifdef TRIGCAP_AUTO_EN
                to_d       = '0;
`endif
                state_d    = (pre_count == '0) ? WAIT_TRIG : PRETRIG;
            end
            PRETRIG: if (sample_valid) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q + 1'b1 == pre_q) state_d = WAIT_TRIG;
            end
            WAIT_TRIG: if (sample_valid) begin
`ifdef TRIGCAP_AUTO_EN
                to_d = to_q + 1'b1;
                if (force_trig && !hit) forced_d = 1'b1;
`endif
                if (hit || force_trig) begin
                    trig_d   = 1'b1;
                    cnt_d    = '0;
                    beat_d   = '0;
                    rd_ptr_d = wr_ptr_q - pre_q;
                    state_d  = (&pre_q) ? READOUT : POSTTRIG;
                end
            end
            // Post-trigger length DEPTH-1-pre equals ~pre in ADDR_W bits.
            POSTTRIG: if (sample_valid) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q + 1'b1 == ~pre_q) state_d = READOUT;
            end
            READOUT: begin
                if (!rd_valid_q || (rd_ready && !rd_last_q)) begin
                    re         = 1'b1;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    rd_valid_d = 1'b1;
                    if (rd_valid_q) beat_d = beat_q + 1'b1;
                    rd_last_d  = rd_valid_q && (beat_q == ADDR_W'(DEPTH - 2));
                end else if (rd_ready && rd_last_q) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    trig_d     = 1'b0;
`ifdef TRIGCAP_AUTO_EN
                    forced_d   = 1'b0;
`endif
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            beat_q     <= '0;
            pre_q      <= '0;
            level_q    <= '0;
            fall_q     <= 1'b0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            trig_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
`ifdef TRIGCAP_AUTO_EN
            to_q       <= '0;
            forced_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            pre_q      <= pre_d;
            level_q    <= level_d;
            fall_q     <= fall_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            trig_q     <= trig_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
`ifdef TRIGCAP_AUTO_EN
            to_q       <= to_d;
            forced_q   <= forced_d;
`endif
        end
    end

    trigcap_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (sample_in),
        .re_i    (re),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_q)
    );

    // RAM output is unreset; mask it so rd_data reads 0 whenever no beat is offered.
    assign rd_data   = rd_valid_q ? ram_q : '0;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign busy      = (state_q != IDLE);
    assign triggered = trig_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench for trigger_capture: a sample-list model predicts the DEPTH-beat window per capture.
module tb_trigger_capture;
    localparam int DEPTH = 256, NS = 2048, AUTO_TO = 1000;

    logic       clk = 1'b0, rst = 1'b0;
    logic [7:0] sample_in = '0, trig_level = '0, pre_count = '0, rd_data;
    logic       sample_valid = 1'b0, arm = 1'b0, trig_falling = 1'b0, rd_ready = 1'b0;
    logic       rd_valid, rd_last, busy, triggered, trig_forced;

    trigger_capture #(.WIDTH(8), .DEPTH(DEPTH), .AUTO_TIMEOUT(AUTO_TO)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid), .arm(arm),
        .trig_level(trig_level), .trig_falling(trig_falling), .pre_count(pre_count),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .busy(busy), .triggered(triggered), .trig_forced(trig_forced));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int s [NS];
    int exp_a [DEPTH];
    logic [7:0] got [DEPTH];
    bit has_trig, exp_forced, cap_active = 0, stalled = 0;
    int nbeat = 0;
    logic [7:0] held = '0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int gen(input int mode, input int i);
        int p;
        if (mode == 0) return i % 256;
        if (mode == 1) begin
            p = (48 + i) % 510;
            return (p <= 255) ? p : 510 - p;
        end
        return 16;
    endfunction

    // The capture window is the DEPTH accepted samples starting pre before the trigger sample.
    task automatic build_model(input int mode, input int lvl, input int fall, input int pre);
        int t, wt;
        bit hit;
        t = 0; wt = 0; has_trig = 0; exp_forced = 0;
        for (int i = 0; i < NS; i++) s[i] = gen(mode, i);
        for (int i = pre; i < NS - DEPTH && !has_trig; i++) begin
            hit = (i > 0) && (fall != 0 ? (s[i-1] > lvl && s[i] <= lvl)
                                        : (s[i-1] < lvl && s[i] >= lvl));
            wt++;
`ifdef TRIGCAP_AUTO_EN
            if (!hit && wt == AUTO_TO) exp_forced = 1;
`endif
            if (hit || exp_forced) begin has_trig = 1; t = i; end
        end
        for (int k = 0; k < DEPTH; k++) exp_a[k] = has_trig ? s[t - pre + k] : 0;
    endtask

    always @(negedge clk) begin
        if (cap_active) begin
            if (rd_valid) begin
                if (!has_trig || nbeat >= DEPTH) chk(0, "extra_beat", rd_data, nbeat);
                else begin
                    chk(rd_data == exp_a[nbeat][7:0], "rd_data", rd_data, exp_a[nbeat]);
                    chk(rd_last == (nbeat == DEPTH - 1), "rd_last", rd_last, int'(nbeat == DEPTH - 1));
                    chk(triggered && (trig_forced == exp_forced), "trig_flags",
                        {triggered, trig_forced}, {1'b1, exp_forced});
                    if (stalled) chk(rd_data == held, "stall_hold", rd_data, held);
                    got[nbeat] = rd_data;
                    if (rd_ready) nbeat++;
                end
            end else begin
                if (stalled) chk(0, "stall_valid_drop", 0, 1);
                if (nbeat < DEPTH) chk(busy, "busy", busy, 1);
            end
            stalled = rd_valid && !rd_ready;
            held = rd_data;
        end
    end

    task automatic reset_pulse();
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk(!busy && !triggered && !rd_valid && !rd_last && !trig_forced, "reset_outputs",
            {busy, triggered, rd_valid, rd_last, trig_forced}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic run(input int mode, input int lvl, input int fall, input int pre,
                       input bit gaps, input bit bp, input bit arm_ro, input int abort_after,
                       input int budget);
        int idx, cyc, tcnt;
        bit v;
        build_model(mode, lvl, fall, pre);
        @(posedge clk); #1;
        arm = 1'b1; sample_valid = 1'b0; rd_ready = 1'b0;
        trig_level = 8'(lvl); trig_falling = fall[0]; pre_count = 8'(pre);
        @(posedge clk); #1;
        arm = 1'b0;
        nbeat = 0; stalled = 0; idx = 0; cyc = 0; tcnt = 0;
        cap_active = 1;
        while (nbeat < DEPTH && cyc < budget) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            sample_valid = v;
            sample_in = v ? 8'(s[idx]) : 8'($urandom);
            if (v && idx < NS - 1) idx++;
            rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            arm = arm_ro && rd_valid;
            @(posedge clk); #1;
            cyc++;
            if (triggered) tcnt++;
            if (abort_after >= 0 && tcnt > abort_after) begin
                cap_active = 0;
                sample_valid = 1'b0; arm = 1'b0;
                chk(busy && triggered && !rd_valid, "in_posttrig", {busy, triggered, rd_valid}, 3'b110);
                reset_pulse();
                return;
            end
        end
        sample_valid = 1'b0; rd_ready = 1'b0; arm = 1'b0;
        if (has_trig) begin
            chk(nbeat == DEPTH, "capture_done", nbeat, DEPTH);
            @(negedge clk);
            chk(!busy && !triggered && !trig_forced && !rd_valid, "back_to_idle",
                {busy, triggered, trig_forced, rd_valid}, 0);
            cap_active = 0;
            if (nbeat != DEPTH) reset_pulse();
        end else begin
            chk(busy, "still_waiting", busy, 1);
            chk(nbeat == 0, "no_beats", nbeat, 0);
            cap_active = 0;
            reset_pulse();
        end
    endtask

    initial begin
        // Reset held mid-ramp with arm asserted: nothing may leave idle.
        rst = 1'b0; sample_valid = 1'b1; arm = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample_in = 8'(i);
            @(negedge clk);
            chk(!busy && !rd_valid && !rd_last && !triggered && !trig_forced && rd_data == 8'h00,
                "reset_state", {busy, rd_valid, rd_last, triggered, trig_forced}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b1; arm = 1'b0; sample_valid = 1'b0;
        @(negedge clk);
        chk(!busy, "idle_after_reset", busy, 0);

        run(0, 8'h80, 0, 16, 0, 0, 0, -1, 3000);
        chk(got[0] == 8'h70, "rise_beat0", got[0], 8'h70);
        chk(got[16] == 8'h80, "rise_beat16", got[16], 8'h80);
        chk(got[255] == 8'h6F, "rise_beat255", got[255], 8'h6F);

        run(1, 8'h40, 1, 0, 0, 0, 0, -1, 3000);
        chk(got[0] == 8'h40, "fall_beat0", got[0], 8'h40);
        chk(got[1] == 8'h3F, "fall_beat1", got[1], 8'h3F);

        run(0, 8'h80, 0, 16, 1, 1, 0, -1, 4000);
        chk(got[0] == 8'h70, "bp_beat0", got[0], 8'h70);
        chk(got[16] == 8'h80, "bp_beat16", got[16], 8'h80);
        chk(got[255] == 8'h6F, "bp_beat255", got[255], 8'h6F);

        run(0, 8'h80, 0, 255, 0, 0, 0, -1, 3000);
        chk(got[0] == 8'h81, "pre255_beat0", got[0], 8'h81);
        chk(got[255] == 8'h80, "pre255_trig_beat", got[255], 8'h80);

`ifdef TRIGCAP_AUTO_EN
        run(2, 8'h80, 0, 0, 0, 0, 0, -1, 3000);
        chk(got[0] == 8'h10 && got[255] == 8'h10, "auto_beats", got[255], 8'h10);
`else
        run(2, 8'h80, 0, 0, 0, 0, 0, -1, 5000);
`endif

        run(0, 8'h80, 0, 16, 0, 0, 0, 20, 3000);
        run(0, 8'h80, 0, 16, 0, 0, 1, -1, 3000);
        chk(got[0] == 8'h70, "rearm_beat0", got[0], 8'h70);
        chk(got[16] == 8'h80, "rearm_beat16", got[16], 8'h80);
        chk(got[255] == 8'h6F, "rearm_beat255", got[255], 8'h6F);
        repeat (3) @(negedge clk);
        chk(!busy, "arm_in_readout_ignored", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
